// File: rtl/biriscv_div_issue_pkg.sv
// Shared definitions for the divider issue controller: opcode match
// values/masks for the M-extension divide class and the controller states.
package biriscv_div_issue_pkg;

    localparam logic [31:0] INST_DIV       = 32'h02004033;
    localparam logic [31:0] INST_DIV_MASK  = 32'hfe00707f;
    localparam logic [31:0] INST_DIVU      = 32'h02005033;
    localparam logic [31:0] INST_DIVU_MASK = 32'hfe00707f;
    localparam logic [31:0] INST_REM       = 32'h02006033;
    localparam logic [31:0] INST_REM_MASK  = 32'hfe00707f;
    localparam logic [31:0] INST_REMU      = 32'h02007033;
    localparam logic [31:0] INST_REMU_MASK = 32'hfe00707f;

    typedef enum logic [2:0] {
        DIV_ISS_IDLE,
        DIV_ISS_ISSUE,
        DIV_ISS_WAIT,
        DIV_ISS_RESP,
        DIV_ISS_DRAIN
    } div_iss_state_t;

    // True for any of DIV/DIVU/REM/REMU
    function automatic logic is_div_op(input logic [31:0] op);
        return ((op & INST_DIV_MASK)  == INST_DIV)  ||
               ((op & INST_DIVU_MASK) == INST_DIVU) ||
               ((op & INST_REM_MASK)  == INST_REM)  ||
               ((op & INST_REMU_MASK) == INST_REMU);
    endfunction

endpackage

// File: rtl/biriscv_div_issue.sv
// Issue-side controller for the iterative divider: accepts one op, pulses
// the divider, waits for its writeback and hands the result to writeback.
// Optional watchdog enabled by defining BIRISCV_DIV_TIMEOUT_EN.
module biriscv_div_issue
    import biriscv_div_issue_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_opcode_i,
    input  logic [31:0] req_pc_i,
    input  logic [4:0]  req_rd_idx_i,
    input  logic [4:0]  req_ra_idx_i,
    input  logic [4:0]  req_rb_idx_i,
    input  logic [31:0] req_ra_operand_i,
    input  logic [31:0] req_rb_operand_i,
    input  logic        flush_i,
    output logic        div_opcode_valid_o,
    output logic [31:0] div_opcode_opcode_o,
    output logic [31:0] div_opcode_pc_o,
    output logic        div_opcode_invalid_o,
    output logic [4:0]  div_opcode_rd_idx_o,
    output logic [4:0]  div_opcode_ra_idx_o,
    output logic [4:0]  div_opcode_rb_idx_o,
    output logic [31:0] div_opcode_ra_operand_o,
    output logic [31:0] div_opcode_rb_operand_o,
    input  logic        div_writeback_valid_i,
    input  logic [31:0] div_writeback_value_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_pc_o,
    output logic [31:0] wb_value_o,
    output logic        busy_o,
    output logic [4:0]  pending_rd_o,
    output logic        timeout_o
);

    div_iss_state_t state_q, state_d;

    logic [31:0] opcode_q, pc_q, ra_q, rb_q, value_q;
    logic [4:0]  rd_q, ra_idx_q, rb_idx_q;
    logic        accept;
    logic        to_expire;

    // A flush in IDLE withdraws ready so the issue stage never sees a false accept
    assign req_ready_o = (state_q == DIV_ISS_IDLE) && !flush_i;
    assign accept      = req_valid_i && req_ready_o;

    // Next-state logic; flush outranks writeback and wb_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_ISS_IDLE:  if (accept) state_d = is_div_op(req_opcode_i) ? DIV_ISS_ISSUE : DIV_ISS_RESP;
            DIV_ISS_ISSUE: state_d = flush_i ? DIV_ISS_DRAIN : DIV_ISS_WAIT;
            DIV_ISS_WAIT: begin
                if (flush_i)                    state_d = DIV_ISS_DRAIN;
                else if (div_writeback_valid_i) state_d = DIV_ISS_RESP;
                else if (to_expire)             state_d = DIV_ISS_IDLE;
            end
            DIV_ISS_RESP:  if (flush_i || wb_ready_i) state_d = DIV_ISS_IDLE;
            DIV_ISS_DRAIN: if (div_writeback_valid_i || to_expire) state_d = DIV_ISS_IDLE;
            default:       state_d = DIV_ISS_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= DIV_ISS_IDLE;
        else     state_q <= state_d;
    end

    // Request capture and result latch; non-div ops retire with a zero value
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q <= '0;
            pc_q     <= '0;
            rd_q     <= '0;
            ra_idx_q <= '0;
            rb_idx_q <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            value_q  <= '0;
        end else if (accept) begin
            opcode_q <= req_opcode_i;
            pc_q     <= req_pc_i;
            rd_q     <= req_rd_idx_i;
            ra_idx_q <= req_ra_idx_i;
            rb_idx_q <= req_rb_idx_i;
            ra_q     <= req_ra_operand_i;
            rb_q     <= req_rb_operand_i;
            value_q  <= '0;
        end else if (state_q == DIV_ISS_WAIT && div_writeback_valid_i && !flush_i) begin
            value_q  <= div_writeback_value_i;
        end
    end

    assign div_opcode_valid_o      = (state_q == DIV_ISS_ISSUE);
    assign div_opcode_opcode_o     = opcode_q;
    assign div_opcode_pc_o         = pc_q;
    assign div_opcode_invalid_o    = 1'b0;
    assign div_opcode_rd_idx_o     = rd_q;
    assign div_opcode_ra_idx_o     = ra_idx_q;
    assign div_opcode_rb_idx_o     = rb_idx_q;
    assign div_opcode_ra_operand_o = ra_q;
    assign div_opcode_rb_operand_o = rb_q;

    assign wb_valid_o  = (state_q == DIV_ISS_RESP) && !flush_i;
    assign wb_rd_idx_o = rd_q;
    assign wb_pc_o     = pc_q;
    assign wb_value_o  = value_q;

    assign busy_o       = (state_q != DIV_ISS_IDLE);
    assign pending_rd_o = (state_q == DIV_ISS_ISSUE || state_q == DIV_ISS_WAIT ||
                           state_q == DIV_ISS_RESP) ? rd_q : '0;

`ifdef BIRISCV_DIV_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_count_q;
    logic            timeout_q;
    logic            to_fire;

    assign to_expire = (state_q == DIV_ISS_WAIT || state_q == DIV_ISS_DRAIN) &&
                       (to_count_q == TO_W'(TIMEOUT_CYCLES - 1));
    // Expiry only counts when no writeback or flush already moves the FSM
    assign to_fire   = to_expire && !div_writeback_valid_i &&
                       !(flush_i && state_q == DIV_ISS_WAIT);

    // Watchdog: restart on entry to WAIT/DRAIN, sticky flag until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            to_count_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if ((state_d == DIV_ISS_WAIT || state_d == DIV_ISS_DRAIN) && state_d != state_q)
                to_count_q <= '0;
            else if (state_q == DIV_ISS_WAIT || state_q == DIV_ISS_DRAIN)
                to_count_q <= to_count_q + 1'b1;
            if (to_fire)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign to_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_biriscv_div_issue.sv
// Directed bench for biriscv_div_issue with a behavioural divider stand-in
// (about 34 cycles, 2 for a repeated op/operand set).
module tb_biriscv_div_issue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid_i, req_ready_o, flush_i;
    logic [31:0] req_opcode_i, req_pc_i, req_ra_operand_i, req_rb_operand_i;
    logic [4:0]  req_rd_idx_i, req_ra_idx_i, req_rb_idx_i;
    logic        div_opcode_valid_o, div_opcode_invalid_o;
    logic [31:0] div_opcode_opcode_o, div_opcode_pc_o, div_opcode_ra_operand_o, div_opcode_rb_operand_o;
    logic [4:0]  div_opcode_rd_idx_o, div_opcode_ra_idx_o, div_opcode_rb_idx_o;
    logic        div_writeback_valid_i;
    logic [31:0] div_writeback_value_i;
    logic        wb_valid_o, wb_ready_i, busy_o, timeout_o;
    logic [4:0]  wb_rd_idx_o, pending_rd_o;
    logic [31:0] wb_pc_o, wb_value_o;

    biriscv_div_issue u_dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_opcode_i(req_opcode_i), .req_pc_i(req_pc_i),
        .req_rd_idx_i(req_rd_idx_i), .req_ra_idx_i(req_ra_idx_i), .req_rb_idx_i(req_rb_idx_i),
        .req_ra_operand_i(req_ra_operand_i), .req_rb_operand_i(req_rb_operand_i),
        .flush_i(flush_i),
        .div_opcode_valid_o(div_opcode_valid_o), .div_opcode_opcode_o(div_opcode_opcode_o),
        .div_opcode_pc_o(div_opcode_pc_o), .div_opcode_invalid_o(div_opcode_invalid_o),
        .div_opcode_rd_idx_o(div_opcode_rd_idx_o), .div_opcode_ra_idx_o(div_opcode_ra_idx_o),
        .div_opcode_rb_idx_o(div_opcode_rb_idx_o),
        .div_opcode_ra_operand_o(div_opcode_ra_operand_o), .div_opcode_rb_operand_o(div_opcode_rb_operand_o),
        .div_writeback_valid_i(div_writeback_valid_i), .div_writeback_value_i(div_writeback_value_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_idx_o(wb_rd_idx_o), .wb_pc_o(wb_pc_o), .wb_value_o(wb_value_o),
        .busy_o(busy_o), .pending_rd_o(pending_rd_o), .timeout_o(timeout_o)
    );

    // ---------------- divider stand-in ----------------
    logic [5:0]  m_cnt = '0;
    logic [31:0] m_res = '0;
    logic [2:0]  m_f3_last = '0;
    logic [31:0] m_a_last = '0, m_b_last = '0;
    logic        m_has_last = 1'b0;
    logic        m_suppress = 1'b0;

    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f3)
            3'd4:    return (b == 0) ? 32'hFFFFFFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5:    return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    always @(posedge clk) begin
        if (div_opcode_valid_o) begin
            m_res <= ref_div(div_opcode_opcode_o[14:12], div_opcode_ra_operand_o, div_opcode_rb_operand_o);
            m_cnt <= (m_has_last && m_f3_last == div_opcode_opcode_o[14:12] &&
                      m_a_last == div_opcode_ra_operand_o && m_b_last == div_opcode_rb_operand_o) ? 6'd2 : 6'd34;
            m_has_last <= 1'b1;
            m_f3_last  <= div_opcode_opcode_o[14:12];
            m_a_last   <= div_opcode_ra_operand_o;
            m_b_last   <= div_opcode_rb_operand_o;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 6'd1;
        end
    end
    assign div_writeback_valid_i = (m_cnt == 6'd1) && !m_suppress;
    assign div_writeback_value_i = m_res;

    // ---------------- bookkeeping ----------------
    int cyc = 0, issue_cyc = 0, n_starts = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_opcode_valid_o) begin
            issue_cyc <= cyc;
            n_starts  <= n_starts + 1;
        end
    end

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic issue(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] pc);
        int n;
        n = 0;
        @(negedge clk);
        req_valid_i = 1'b1; req_opcode_i = op; req_pc_i = pc; req_rd_idx_i = rd;
        req_ra_idx_i = rd + 5'd1; req_rb_idx_i = rd + 5'd2;
        req_ra_operand_i = a; req_rb_operand_i = b;
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_bound", 32'(n), 32'd0);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_wb(output logic seen);
        int n;
        n = 0;
        while (!wb_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        seen = wb_valid_o;
    endtask

    function automatic logic [31:0] mkop(input logic [31:0] base, input logic [4:0] rd);
        return base | (32'(rd) << 7) | (32'(rd + 5'd1) << 15) | (32'(rd + 5'd2) << 20);
    endfunction

    typedef struct {
        logic [31:0] base;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] exp;
        logic        is_div;
        logic        fast;
    } vec_t;

    vec_t vecs[9];

    // Optional watchdog instance with the divider never answering
`ifdef BIRISCV_DIV_TIMEOUT_EN
    logic        t_req_valid, t_req_ready, t_div_valid, t_div_inv, t_wb_valid, t_busy, t_timeout;
    logic [31:0] t_div_op, t_div_pc, t_div_ra, t_div_rb, t_wb_pc, t_wb_value;
    logic [4:0]  t_div_rd, t_div_raidx, t_div_rbidx, t_wb_rd, t_pending;

    biriscv_div_issue #(.TIMEOUT_CYCLES(8)) u_dut_to (
        .clk(clk), .rst(rst),
        .req_valid_i(t_req_valid), .req_ready_o(t_req_ready),
        .req_opcode_i(32'h02005033), .req_pc_i(32'h3000),
        .req_rd_idx_i(5'd15), .req_ra_idx_i(5'd1), .req_rb_idx_i(5'd2),
        .req_ra_operand_i(32'd77), .req_rb_operand_i(32'd7),
        .flush_i(1'b0),
        .div_opcode_valid_o(t_div_valid), .div_opcode_opcode_o(t_div_op),
        .div_opcode_pc_o(t_div_pc), .div_opcode_invalid_o(t_div_inv),
        .div_opcode_rd_idx_o(t_div_rd), .div_opcode_ra_idx_o(t_div_raidx),
        .div_opcode_rb_idx_o(t_div_rbidx),
        .div_opcode_ra_operand_o(t_div_ra), .div_opcode_rb_operand_o(t_div_rb),
        .div_writeback_valid_i(1'b0), .div_writeback_value_i(32'd0),
        .wb_valid_o(t_wb_valid), .wb_ready_i(1'b1),
        .wb_rd_idx_o(t_wb_rd), .wb_pc_o(t_wb_pc), .wb_value_o(t_wb_value),
        .busy_o(t_busy), .pending_rd_o(t_pending), .timeout_o(t_timeout)
    );
`endif

    initial begin
        logic seen;
        int   s0, n, pulses;
        logic [31:0] val_seen;

        vecs[0] = '{32'h02004033, 32'hFFFFFFF9, 32'd2,        5'd1, 32'h1000, 32'hFFFFFFFD, 1'b1, 1'b0};
        vecs[1] = '{32'h02006033, 32'hFFFFFFF9, 32'd2,        5'd2, 32'h1004, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[2] = '{32'h02005033, 32'd5,        32'd0,        5'd3, 32'h1008, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[3] = '{32'h02007033, 32'd5,        32'd0,        5'd4, 32'h100C, 32'h00000005, 1'b1, 1'b0};
        vecs[4] = '{32'h02004033, 32'h80000000, 32'hFFFFFFFF, 5'd5, 32'h1010, 32'h80000000, 1'b1, 1'b0};
        vecs[5] = '{32'h00000033, 32'd3,        32'd4,        5'd6, 32'h1014, 32'h00000000, 1'b0, 1'b0};
        vecs[6] = '{32'h02004033, 32'd100,      32'd7,        5'd7, 32'h1018, 32'd14,       1'b1, 1'b0};
        vecs[7] = '{32'h02004033, 32'd100,      32'd7,        5'd8, 32'h101C, 32'd14,       1'b1, 1'b1};
        vecs[8] = '{32'h02004033, 32'd0,        32'd0,        5'd0, 32'h1020, 32'hFFFFFFFF, 1'b1, 1'b0};

        rst = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1;
        req_opcode_i = '0; req_pc_i = '0; req_rd_idx_i = '0; req_ra_idx_i = '0; req_rb_idx_i = '0;
        req_ra_operand_i = '0; req_rb_operand_i = '0;
`ifdef BIRISCV_DIV_TIMEOUT_EN
        t_req_valid = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_div_valid", 32'(div_opcode_valid_o), 32'd0);
        chk("rst_pending", 32'(pending_rd_o), 32'd0);
        chk("rst_wb_value", wb_value_o, 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_invalid", 32'(div_opcode_invalid_o), 32'd0);
        rst = 1'b0;

        // Table-driven ops
        for (int i = 0; i < 9; i++) begin
            s0 = n_starts;
            issue(mkop(vecs[i].base, vecs[i].rd), vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].pc);
            chk($sformatf("v%0d_pending_rd", i), 32'(pending_rd_o), 32'(vecs[i].rd));
            chk($sformatf("v%0d_req_ready_busy", i), 32'(req_ready_o), 32'd0);
            wait_wb(seen);
            chk($sformatf("v%0d_wb_seen", i), 32'(seen), 32'd1);
            chk($sformatf("v%0d_wb_value", i), wb_value_o, vecs[i].exp);
            chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd_idx_o), 32'(vecs[i].rd));
            chk($sformatf("v%0d_wb_pc", i), wb_pc_o, vecs[i].pc);
            if (vecs[i].fast) chk($sformatf("v%0d_fast_latency_le4", i), 32'((cyc - issue_cyc) <= 4), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_idle_after", i), 32'(busy_o), 32'd0);
            chk($sformatf("v%0d_starts", i), 32'(n_starts - s0), 32'(vecs[i].is_div));
        end

        // Flush 10 cycles into WAIT
        issue(mkop(32'h02005033, 5'd9), 32'd20, 32'd4, 5'd9, 32'h2000);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_pending_rd", 32'(pending_rd_o), 32'd0);
        chk("flush_drain_busy", 32'(busy_o), 32'd1);
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            if (wb_valid_o) pulses++;
            @(negedge clk);
        end
        chk("flush_no_wb", 32'(pulses), 32'd0);
        chk("flush_drained_idle", 32'(busy_o), 32'd0);
        issue(mkop(32'h02005033, 5'd10), 32'd9, 32'd3, 5'd10, 32'h2004);
        pulses = 0; val_seen = '0;
        for (int k = 0; k < 80; k++) begin
            if (wb_valid_o) begin pulses++; val_seen = wb_value_o; end
            @(negedge clk);
        end
        chk("post_flush_one_wb", 32'(pulses), 32'd1);
        chk("post_flush_value", val_seen, 32'd3);

        // Writeback back-pressure for 5 cycles
        wb_ready_i = 1'b0;
        issue(mkop(32'h02007033, 5'd11), 32'd17, 32'd5, 5'd11, 32'h2008);
        wait_wb(seen);
        chk("stall_wb_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("stall_wb_valid", 32'(wb_valid_o), 32'd1);
            chk("stall_wb_value", wb_value_o, 32'd2);
            chk("stall_wb_tag", {wb_rd_idx_o, wb_pc_o[26:0]}, {5'd11, 27'h2008});
            chk("stall_req_ready", 32'(req_ready_o), 32'd0);
            @(negedge clk);
        end
        wb_ready_i = 1'b1;
        @(negedge clk);
        chk("stall_release_idle", 32'(busy_o), 32'd0);
        chk("stall_release_ready", 32'(req_ready_o), 32'd1);

        // Flush while in RESP drops the result
        wb_ready_i = 1'b0;
        issue(mkop(32'h00000033, 5'd13), 32'd1, 32'd1, 5'd13, 32'h200C);
        wait_wb(seen);
        flush_i = 1'b1;
        #1;
        chk("resp_flush_wb_valid", 32'(wb_valid_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0; wb_ready_i = 1'b1;
        chk("resp_flush_idle", 32'(busy_o), 32'd0);

        // Flush in IDLE blocks the accept
        s0 = n_starts;
        req_valid_i = 1'b1; flush_i = 1'b1;
        req_opcode_i = mkop(32'h02004033, 5'd12);
        #1;
        chk("idle_flush_ready", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        req_valid_i = 1'b0; flush_i = 1'b0;
        chk("idle_flush_no_accept", 32'(busy_o), 32'd0);
        @(negedge clk);
        chk("idle_flush_no_start", 32'(n_starts - s0), 32'd0);

        // Reset mid-operation; the late divider pulse must be ignored
        issue(mkop(32'h02004033, 5'd14), 32'd1000, 32'd3, 5'd14, 32'h2010);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_ready", 32'(req_ready_o), 32'd1);
        chk("midrst_pending", 32'(pending_rd_o), 32'd0);
        pulses = 0; n = 0;
        for (int k = 0; k < 50; k++) begin
            if (wb_valid_o) pulses++;
            if (busy_o) n++;
            @(negedge clk);
        end
        chk("midrst_stray_wb", 32'(pulses), 32'd0);
        chk("midrst_stray_busy", 32'(n), 32'd0);

`ifdef BIRISCV_DIV_TIMEOUT_EN
        chk("to_flag_initial", 32'(t_timeout), 32'd0);
        t_req_valid = 1'b1;
        #1;
        chk("to_ready", 32'(t_req_ready), 32'd1);
        @(negedge clk);
        t_req_valid = 1'b0;
        n = 0;
        while (t_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", 32'(n), 32'd9);
        chk("to_flag_set", 32'(t_timeout), 32'd1);
        chk("to_idle", 32'(t_busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("to_flag_sticky", 32'(t_timeout), 32'd1);
`else
        chk("timeout_tied_low", 32'(timeout_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
